// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads the word at the PC over an Avalon-style bus,
// byte-swaps it into the IR, and flags halt, misaligned fetches and bus timeouts.
module instr_fetch #(
  parameter int SWAP_BYTES     = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] pc_address,
  input  logic        pc_halt,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic [31:0] instr,
  output logic [31:0] instr_addr,
  output logic        instr_valid,
  output logic        busy,
  output logic        halted,
  output logic        fetch_err
);

  // A disabled timeout still gets a 1-bit counter so the declaration stays legal
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, READ, HALT, ERR} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   rd_swapped;
  logic          timeout_hit;

  always_comb begin
    rd_swapped = (SWAP_BYTES != 0)
               ? {mem_readdata[7:0], mem_readdata[15:8], mem_readdata[23:16], mem_readdata[31:24]}
               : mem_readdata;
  end

  // True on the stall edge that would bring the counter up to the limit
  always_comb begin
    timeout_hit = (TIMEOUT_CYCLES != 0) &&
                  ((32'(wait_cnt) + 32'd1) == 32'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      mem_address    <= '0;
      mem_read       <= 1'b0;
      mem_byteenable <= 4'h0;
      instr          <= '0;
      instr_addr     <= '0;
      instr_valid    <= 1'b0;
      busy           <= 1'b0;
      halted         <= 1'b0;
      fetch_err      <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fetch_req) begin
            if (pc_halt) begin
              halted <= 1'b1;
              state  <= HALT;
            end else if (pc_address[1:0] != 2'b00) begin
              fetch_err <= 1'b1;
              state     <= ERR;
            end else begin
              mem_address    <= {pc_address[31:2], 2'b00};
              mem_read       <= 1'b1;
              mem_byteenable <= 4'hF;
              busy           <= 1'b1;
              wait_cnt       <= '0;
              state          <= READ;
            end
          end
        end
        READ: begin
          if (!mem_waitrequest) begin
            instr          <= rd_swapped;
            instr_addr     <= mem_address;
            instr_valid    <= 1'b1;
            mem_read       <= 1'b0;
            mem_byteenable <= 4'h0;
            busy           <= 1'b0;
            state          <= IDLE;
          end else if (timeout_hit) begin
            mem_read       <= 1'b0;
            mem_byteenable <= 4'h0;
            busy           <= 1'b0;
            fetch_err      <= 1'b1;
            state          <= ERR;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CNT_ONE;
          end
        end
        default: begin
          // HALT and ERR are terminal until reset
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed and randomized fetches compared
// against a transaction-level model of the fetch unit.
module tb_instr_fetch;

  localparam int TO = 4;
  localparam int M_IDLE = 0;
  localparam int M_HALT = 1;
  localparam int M_ERR  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] pc_address = '0;
  logic        pc_halt = 1'b0;
  logic [31:0] mem_address;
  logic        mem_read;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata = '0;
  logic        mem_waitrequest = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic        instr_valid;
  logic        busy;
  logic        halted;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  int          mode;
  logic        exp_read;
  logic [31:0] exp_addr;
  logic [31:0] exp_instr;
  logic [31:0] exp_iaddr;
  logic        exp_valid;
  logic        exp_halted;
  logic        exp_err;

  instr_fetch #(.SWAP_BYTES(1), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_address(pc_address),
    .pc_halt(pc_halt), .mem_address(mem_address), .mem_read(mem_read),
    .mem_byteenable(mem_byteenable), .mem_readdata(mem_readdata),
    .mem_waitrequest(mem_waitrequest), .instr(instr), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .busy(busy), .halted(halted), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] swap_model(input logic [31:0] d);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(3-i) +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    checkOutput({tag, "/mem_read"}, 32'(mem_read), 32'(exp_read));
    checkOutput({tag, "/busy"}, 32'(busy), 32'(exp_read));
    checkOutput({tag, "/byteenable"}, 32'(mem_byteenable), exp_read ? 32'hF : 32'h0);
    if (exp_read) checkOutput({tag, "/mem_address"}, mem_address, exp_addr);
    checkOutput({tag, "/instr"}, instr, exp_instr);
    checkOutput({tag, "/instr_addr"}, instr_addr, exp_iaddr);
    checkOutput({tag, "/instr_valid"}, 32'(instr_valid), 32'(exp_valid));
    checkOutput({tag, "/halted"}, 32'(halted), 32'(exp_halted));
    checkOutput({tag, "/fetch_err"}, 32'(fetch_err), 32'(exp_err));
  endtask

  task automatic model_clear();
    mode = M_IDLE; exp_read = 0; exp_addr = '0; exp_instr = '0; exp_iaddr = '0;
    exp_valid = 0; exp_halted = 0; exp_err = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mem_waitrequest = 1'b0;
    #3;
    model_clear();
    check_all("reset");
    checkOutput("reset/mem_address", mem_address, 32'h0);
    tick();
    reset = 1'b1;
  endtask

  // One fetch request, with the given number of waitrequest cycles on the bus
  task automatic applyStimulus(input logic [31:0] pc, input logic halt, input logic [31:0] data,
                               input int stalls, input logic poke);
    logic [31:0] junk;
    fetch_req = 1'b1; pc_address = pc; pc_halt = halt;
    mem_waitrequest = 1'b1; junk = $urandom; mem_readdata = junk;
    tick();
    fetch_req = 1'b0; pc_halt = 1'b0; junk = $urandom; pc_address = junk;
    exp_valid = 0;
    if (mode == M_IDLE) begin
      if (halt) begin
        mode = M_HALT; exp_halted = 1;
      end else if (pc[1:0] != 2'b00) begin
        mode = M_ERR; exp_err = 1;
      end else begin
        exp_read = 1; exp_addr = pc;
      end
    end
    check_all("accept");
    if (exp_read) begin
      for (int k = 0; k <= stalls; k++) begin
        mem_waitrequest = (k < stalls);
        junk = $urandom;
        mem_readdata = (k < stalls) ? junk : data;
        if (poke && k == 0) begin
          fetch_req = 1'b1; pc_address = pc + 32'h100;
        end
        tick();
        fetch_req = 1'b0;
        if (k < stalls) begin
          if (k + 1 == TO) begin
            exp_read = 0; exp_err = 1; mode = M_ERR;
            check_all("timeout");
            break;
          end
          check_all("stall");
        end else begin
          exp_read = 0; exp_valid = 1; exp_instr = swap_model(data); exp_iaddr = pc;
          check_all("complete");
          exp_valid = 0;
        end
      end
    end
    mem_waitrequest = 1'b0;
  endtask

  initial begin
    logic [31:0] rpc;
    logic [31:0] rdata;
    model_clear();
    #1;
    do_reset();

    $display("[TB] zero-wait and stalled fetches");
    applyStimulus(32'hBFC0_0000, 1'b0, 32'h0C00_F03C, 0, 1'b0);
    checkOutput("t1/instr_const", instr, 32'h3CF0_000C);
    applyStimulus(32'hBFC0_0004, 1'b0, 32'h1234_5678, 3, 1'b0);
    checkOutput("t2/instr_const", instr, 32'h7856_3412);

    $display("[TB] randomized fetches");
    for (int n = 0; n < 12; n++) begin
      rpc = $urandom; rpc[1:0] = 2'b00;
      rdata = $urandom;
      applyStimulus(rpc, 1'b0, rdata, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] fetch request during READ and back-to-back");
    applyStimulus(32'h0040_0000, 1'b0, 32'hDEAD_BEEF, 2, 1'b1);
    applyStimulus(32'h0040_0004, 1'b0, 32'hCAFE_F00D, 0, 1'b0);

    $display("[TB] reset during a stalled read");
    fetch_req = 1'b1; pc_address = 32'h0000_1000; pc_halt = 1'b0; mem_waitrequest = 1'b1;
    tick();
    fetch_req = 1'b0;
    exp_read = 1; exp_addr = 32'h0000_1000;
    check_all("prereset");
    tick();
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check_all("midreset");
    checkOutput("midreset/mem_address", mem_address, 32'h0);
    mem_waitrequest = 1'b0;
    tick();
    check_all("inreset");
    reset = 1'b1;
    tick();
    check_all("postreset");
    applyStimulus(32'h0000_2000, 1'b0, 32'hA1B2_C3D4, 1, 1'b0);

    $display("[TB] misaligned fetch");
    applyStimulus(32'hBFC0_0002, 1'b0, 32'h1111_1111, 0, 1'b0);
    applyStimulus(32'hBFC0_0008, 1'b0, 32'h2222_2222, 0, 1'b0);
    do_reset();

    $display("[TB] bus timeout");
    applyStimulus(32'h0000_3000, 1'b0, 32'h0102_0304, 0, 1'b0);
    applyStimulus(32'h0000_3004, 1'b0, 32'h0506_0708, 10, 1'b0);
    checkOutput("timeout/instr_kept", instr, 32'h0403_0201);
    applyStimulus(32'h0000_3008, 1'b0, 32'h0A0B_0C0D, 0, 1'b0);
    do_reset();

    $display("[TB] halt");
    applyStimulus(32'hBFC0_0002, 1'b1, 32'h3333_3333, 0, 1'b0);
    applyStimulus(32'hBFC0_0010, 1'b0, 32'h4444_4444, 0, 1'b0);
    applyStimulus(32'hBFC0_0014, 1'b1, 32'h5555_5555, 0, 1'b0);
    tick();
    check_all("halt_hold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
